logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

Shares one 64-bit logic unit between two requesters using a valid/ready handshake and round-robin arbitration. Each granted operation is latched, executed for one cycle and returned on a single response channel tagged with the requester ID. Per-requester completion counters support debug. The block sits between the two requesting datapath clients and the combinational logic unit.

## Interface
- WIDTH, 64, operand/result width; fixed at 64 to match the logic unit.
- CNT_W, 16, width of each completion counter.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_sel  in  3  requester 0 opcode: 000 AND, 001 XOR, 010 NAND, 011 OR, 100 NOT a, 101 NOR, 110 two's complement of a, 111 XNOR.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel: as above, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the operation.
- rsp_data  out  WIDTH  operation result.
- busy  out  1  high whenever state is not IDLE.
- cnt0, cnt1  out  CNT_W  completed-response counts per requester.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE, on any valid request:
  - Grant requester: the only valid one; if both are valid, the one selected by priority pointer `ptr`.
  - Assert granted reqN_ready combinationally in the same cycle.
  - Latch a, b, sel and id into operand registers; go to EXEC.
- IDLE, with no valid request: stay in IDLE. req*_ready is never high outside IDLE, and never high for both requesters.
- EXEC:
  - Logic unit evaluates the latched operands.
  - Register result into rsp_data and id into rsp_id; set rsp_valid; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_data and rsp_id stable until rsp_ready.
  - On handshake: clear rsp_valid; set ptr = ~rsp_id; increment cnt[rsp_id]; go to IDLE.
- Requester rules:
  - Once asserted, valid must stay high and operands stable until ready.
  - A requester may deassert valid only after its handshake.
- Arithmetic:
  - All results are WIDTH bits.
  - sel 110 wraps modulo 2^64, so a=0 gives 0.
  - Counters wrap from 2^CNT_W-1 to 0.
- Reset values: state IDLE, ptr=0 (requester 0 preferred), rsp_valid=0, rsp_data=0, rsp_id=0, cnt0=cnt1=0, busy=0, req*_ready=0.
- Reset mid-operation: the in-flight operation is discarded with no response and no counter update. Requesters whose ready was already seen re-issue as required.

## Timing
- Accept in cycle N (valid & ready) -> rsp_valid high from cycle N+2.
- Response handshake in cycle M -> IDLE in M+1; the next accept is possible in cycle M+1.
- Minimum spacing between accepts: 3 cycles with rsp_ready held high.
- Two continuously valid requesters are served strictly alternately. Neither waits more than one other operation.
- rsp_ready held low stalls the block indefinitely. No request is accepted while stalled.
- rst acts immediately (asynchronous assert); release is synchronous to clk.

## Structure
- Shared package holds:
  - opcode constants OP_AND..OP_XNOR (3 bits);
  - state encodings ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2;
  - WIDTH default.
- One natural sub-module: rr_arbiter2, a combinational two-way grant computed from valids and ptr.
- The existing logic_unit is instantiated once and fed from the operand registers.
- FSM, operand/result registers and counters live in the top.

## Test plan
- Reset: assert rst for 3 cycles -> rsp_valid=0, rsp_data=0, cnt0=cnt1=0, busy=0, req0_ready=req1_ready=0.
- Single op: req0 a=0xF0F0_F0F0_F0F0_F0F0, b=0xFF00_FF00_FF00_FF00, sel=000, rsp_ready=1 -> rsp_data=0xF000_F000_F000_F000 and rsp_id=0 two cycles after accept; cnt0=1.
- Contention: both valid continuously for 4 operations from reset -> rsp_id sequence 0,1,0,1; cnt0=cnt1=2; never both ready in the same cycle.
- Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_data and rsp_id stable, rsp_valid held, both ready low; the handshake then completes once.
- Width and wrap:
  - sel=110: a=0 -> 0; a=1 -> 0xFFFF_FFFF_FFFF_FFFF.
  - sel=100 on a=0 -> all ones.
  - Preload cnt0 to 0xFFFF via 65535 ops (or force) -> next completion gives cnt0=0.
- Reset mid-op: rst pulse during EXEC -> no rsp_valid, counters unchanged at 0, state IDLE. A following req1 op completes normally with rsp_id=1.

Source files
------------

// File: rtl/logic_unit_arbiter_pkg.sv
// rtl/logic_unit_arbiter_pkg.sv - shared constants and types for the logic unit arbiter
// Contents: WIDTH default, 3-bit opcodes OP_AND..OP_XNOR, FSM state encoding state_t.
package logic_unit_arbiter_pkg;

  localparam int WIDTH = 64;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NEG  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/logic_unit.sv
// rtl/logic_unit.sv - combinational 64-bit logic unit
// Ports: a_i, b_i operands; sel_i opcode; y_o result (same width as operands).
module logic_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [2:0]   sel_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (sel_i)
      OP_AND:  y_o = a_i & b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      OP_OR:   y_o = a_i | b_i;
      OP_NOT:  y_o = ~a_i;
      OP_NOR:  y_o = ~(a_i | b_i);
      // Two's complement wraps naturally at W bits, so a=0 yields 0.
      OP_NEG:  y_o = ~a_i + W'(1);
      OP_XNOR: y_o = ~(a_i ^ b_i);
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin grant
// Ports: valid0_i, valid1_i request valids; ptr_i preferred requester on contention;
//        gnt0_o, gnt1_o one-hot (or zero) grants.
module rr_arbiter2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic ptr_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  // A lone requester always wins; ptr_i only breaks ties.
  assign gnt0_o = valid0_i & (~valid1_i | ~ptr_i);
  assign gnt1_o = valid1_i & (~valid0_i |  ptr_i);

endmodule

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - shares one logic unit between two requesters, round-robin
// Ports: clk, rst (async active-high); req0_*/req1_* valid/ready request channels with
//        operands a, b and opcode sel; rsp_valid/rsp_ready response channel with rsp_id,
//        rsp_data; busy (not IDLE); cnt0/cnt1 per-requester completion counters.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  state_t             state_q;
  logic               ptr_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2:0]         sel_q;
  logic               id_q;
  logic               rsp_valid_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic               rsp_id_q;
  logic [CNT_W-1:0]   cnt0_q;
  logic [CNT_W-1:0]   cnt1_q;

  logic               gnt0;
  logic               gnt1;
  logic               accept;
  logic [WIDTH-1:0]   lu_y;

  rr_arbiter2 u_arb (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .ptr_i    (ptr_q),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1)
  );

  logic_unit #(.W(WIDTH)) u_lu (
    .a_i   (a_q),
    .b_i   (b_q),
    .sel_i (sel_q),
    .y_o   (lu_y)
  );

  // Ready is only offered from IDLE; masking with rst keeps it low while reset is held.
  assign req0_ready = gnt0 & (state_q == ST_IDLE) & ~rst;
  assign req1_ready = gnt1 & (state_q == ST_IDLE) & ~rst;
  assign accept     = req0_ready | req1_ready;

  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= OP_AND;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q     <= req1_ready ? req1_a   : req0_a;
            b_q     <= req1_ready ? req1_b   : req0_b;
            sel_q   <= req1_ready ? req1_sel : req0_sel;
            id_q    <= req1_ready;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data_q  <= lu_y;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            // Hand priority to the requester that was not just served.
            ptr_q       <= ~rsp_id_q;
            if (rsp_id_q) begin
              cnt1_q <= cnt1_q + CNT_W'(1);
            end else begin
              cnt0_q <= cnt0_q + CNT_W'(1);
            end
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;

  localparam int W = 64;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
  } op_t;

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
  } pend_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req0_ready;
  logic [W-1:0] req0_a = '0;
  logic [W-1:0] req0_b = '0;
  logic [2:0]   req0_sel = '0;
  logic         req1_valid = 1'b0;
  logic         req1_ready;
  logic [W-1:0] req1_a = '0;
  logic [W-1:0] req1_b = '0;
  logic [2:0]   req1_sel = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic         rsp_id;
  logic [W-1:0] rsp_data;
  logic         busy;
  logic [15:0]  cnt0;
  logic [15:0]  cnt1;

  always #5 clk = ~clk;

  logic_unit_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending requests per requester, accepted-but-unanswered ops,
  // cycles since accept, preferred requester, and completion counts.
  op_t         q0[$];
  op_t         q1[$];
  pend_t       outst[$];
  logic        hs_ids[$];
  int          age = 0;
  logic        pref = 1'b0;
  logic [15:0] m_cnt0 = '0;
  logic [15:0] m_cnt1 = '0;
  int          rdy_mode = 1;
  bit          gen_on = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_op(input op_t o);
    case (o.sel)
      3'd0:    return o.a & o.b;
      3'd1:    return o.a ^ o.b;
      3'd2:    return ~(o.a & o.b);
      3'd3:    return o.a | o.b;
      3'd4:    return ~o.a;
      3'd5:    return ~(o.a | o.b);
      3'd6:    return 64'd0 - o.a;
      default: return ~(o.a ^ o.b);
    endcase
  endfunction

  function automatic op_t mk_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel);
    op_t o;
    o.a = a;
    o.b = b;
    o.sel = sel;
    return o;
  endfunction

  function automatic op_t rand_op();
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       a = '0;
      1:       a = 64'd1;
      2:       a = '1;
      default: ;
    endcase
    return mk_op(a, b, 3'($urandom_range(0, 7)));
  endfunction

  task automatic drive_inputs();
    req0_valid = (q0.size() != 0);
    if (q0.size() != 0) begin
      req0_a = q0[0].a; req0_b = q0[0].b; req0_sel = q0[0].sel;
    end
    req1_valid = (q1.size() != 0);
    if (q1.size() != 0) begin
      req1_a = q1[0].a; req1_b = q1[0].b; req1_sel = q1[0].sel;
    end
    case (rdy_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge,
  // then present new stimulus just after it.
  task automatic step();
    logic  exp_busy, exp_rv, g0, g1, rhs;
    pend_t fr;
    @(negedge clk);
    exp_busy = (outst.size() != 0);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!exp_busy) begin
      if (req0_valid && req1_valid) begin
        g0 = ~pref;
        g1 = pref;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
    check_eq("busy", 64'(busy), 64'(exp_busy));
    check_eq("req0_ready", 64'(req0_ready), 64'(g0));
    check_eq("req1_ready", 64'(req1_ready), 64'(g1));
    exp_rv = exp_busy && (age >= 1);
    check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv) begin
      fr = outst[0];
      check_eq("rsp_id", 64'(rsp_id), 64'(fr.id));
      check_eq("rsp_data", rsp_data, fr.res);
    end
    check_eq("cnt0", 64'(cnt0), 64'(m_cnt0));
    check_eq("cnt1", 64'(cnt1), 64'(m_cnt1));
    rhs = exp_rv && rsp_ready;
    @(posedge clk);
    if (rhs) begin
      fr = outst.pop_front();
      hs_ids.push_back(fr.id);
      if (fr.id) m_cnt1++;
      else m_cnt0++;
      pref = ~fr.id;
    end else if (exp_busy) begin
      age++;
    end
    if (g0) begin
      outst.push_back('{id: 1'b0, res: model_op(q0[0])});
      void'(q0.pop_front());
      age = 0;
    end
    if (g1) begin
      outst.push_back('{id: 1'b1, res: model_op(q1[0])});
      void'(q1.pop_front());
      age = 0;
    end
    #1;
    if (gen_on) begin
      if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_op());
      if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_op());
    end
    drive_inputs();
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((q0.size() + q1.size() + outst.size()) != 0 && n < max_cyc) begin
      step();
      n++;
    end
    check_eq("drain_done", 64'(q0.size() + q1.size() + outst.size()), 64'd0);
  endtask

  // Called just after a rising edge; reset takes effect immediately.
  task automatic do_reset(input int cyc);
    rst = 1'b1;
    #1;
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ready0", 64'(req0_ready), 64'd0);
    check_eq("rst_ready1", 64'(req1_ready), 64'd0);
    repeat (cyc) @(posedge clk);
    #1;
    check_eq("rst_rsp_data", rsp_data, 64'd0);
    check_eq("rst_cnt0", 64'(cnt0), 64'd0);
    check_eq("rst_cnt1", 64'(cnt1), 64'd0);
    check_eq("rst_hold_ready0", 64'(req0_ready), 64'd0);
    check_eq("rst_hold_ready1", 64'(req1_ready), 64'd0);
    rst = 1'b0;
    outst.delete();
    age = 0;
    pref = 1'b0;
    m_cnt0 = '0;
    m_cnt1 = '0;
    drive_inputs();
  endtask

  initial begin
    // Reset with a request pending: ready must stay low throughout.
    q0.push_back(mk_op(64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'b000));
    drive_inputs();
    do_reset(3);

    // Single AND op from requester 0.
    rdy_mode = 1;
    drain(20);
    check_eq("single_cnt0", 64'(cnt0), 64'd1);

    // Contention from reset: strict alternation 0,1,0,1.
    @(posedge clk); #1;
    do_reset(3);
    hs_ids.delete();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(rand_op());
      q1.push_back(rand_op());
    end
    drive_inputs();
    drain(40);
    check_eq("cont_count", 64'(hs_ids.size()), 64'd4);
    for (int i = 0; i < 4 && i < hs_ids.size(); i++)
      check_eq($sformatf("cont_id%0d", i), 64'(hs_ids[i]), 64'(i % 2));
    check_eq("cont_cnt0", 64'(cnt0), 64'd2);
    check_eq("cont_cnt1", 64'(cnt1), 64'd2);

    // Backpressure: response held for several cycles, then one handshake.
    hs_ids.delete();
    rdy_mode = 0;
    q1.push_back(rand_op());
    drive_inputs();
    repeat (7) step();
    rdy_mode = 1;
    drive_inputs();
    drain(20);
    check_eq("bp_handshakes", 64'(hs_ids.size()), 64'd1);

    // Width and wrap corners.
    q1.push_back(mk_op(64'd0, '1, 3'b110));
    q1.push_back(mk_op(64'd1, '0, 3'b110));
    q0.push_back(mk_op(64'd0, '0, 3'b100));
    drive_inputs();
    drain(40);

    // Counter wrap: preload cnt0 at all ones, one more completion returns it to zero.
    force dut.cnt0_q = 16'hFFFF;
    #1;
    release dut.cnt0_q;
    m_cnt0 = 16'hFFFF;
    q0.push_back(rand_op());
    drive_inputs();
    drain(20);
    check_eq("wrap_cnt0", 64'(cnt0), 64'd0);

    // Randomized traffic with random backpressure.
    gen_on = 1'b1;
    rdy_mode = 2;
    repeat (800) step();
    gen_on = 1'b0;
    drain(200);

    // Reset while the accepted op is in EXEC: nothing is returned.
    @(posedge clk); #1;
    do_reset(2);
    rdy_mode = 1;
    q0.push_back(rand_op());
    drive_inputs();
    begin
      int n = 0;
      while (outst.size() == 0 && n < 10) begin
        step();
        n++;
      end
    end
    check_eq("midop_in_exec", 64'(outst.size()), 64'd1);
    do_reset(2);
    check_eq("midop_state_idle", 64'(busy), 64'd0);
    hs_ids.delete();
    q1.push_back(rand_op());
    drive_inputs();
    drain(20);
    check_eq("midop_after_count", 64'(hs_ids.size()), 64'd1);
    if (hs_ids.size() != 0) check_eq("midop_after_id", 64'(hs_ids[0]), 64'd1);
    check_eq("midop_cnt0", 64'(cnt0), 64'd0);
    check_eq("midop_cnt1", 64'(cnt1), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
